// File: rtl/dht_read_scheduler.sv
//============================================================================
// Module  : dht_read_scheduler
// Purpose : Schedules, times out, retries and validates single-wire sensor reads.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module dht_read_scheduler #(
  parameter int PERIOD_TICKS  = 200,
  parameter int SETTLE_TICKS  = 100,
  parameter int TIMEOUT_TICKS = 5,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_10msec,
  input  logic        manual_req,
  input  logic        enable,
  input  logic        ctr_busy,
  input  logic        ctr_done,
  input  logic        ctr_error,
  input  logic [39:0] ctr_frame,
  output logic        start_req,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic        data_valid,
  output logic        fail,
  output logic [7:0]  err_count,
  output logic        sched_busy,
  output logic [2:0]  sched_state
);

  localparam int PW = $clog2(PERIOD_TICKS + 1);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int AW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [AW-1:0] attempt_q, attempt_d;
  logic          pend_q, pend_d;
  logic          retry_q, retry_d;
  logic [39:0]   frame_q, frame_d;
  logic [7:0]    humidity_q, humidity_d;
  logic [7:0]    temperature_q, temperature_d;
  logic          data_valid_q, data_valid_d;
  logic          fail_q, fail_d;
  logic [7:0]    err_count_q, err_count_d;

  logic       w_period_hit, w_pend_now, w_issue_idle;
  logic       w_settle_hit, w_timeout_hit;
  logic       w_check_good, w_attempt_fail, w_can_retry;
  logic [7:0] w_sum;

  assign w_period_hit  = enable && tick_10msec && (period_cnt_q == PW'(PERIOD_TICKS - 1));
  assign w_pend_now    = pend_q || manual_req || w_period_hit;
  assign w_issue_idle  = (state_q == S_IDLE) && w_pend_now && !ctr_busy;
  assign w_settle_hit  = tick_10msec && (settle_cnt_q == SW'(SETTLE_TICKS - 1));
  assign w_timeout_hit = tick_10msec && (timeout_cnt_q == TW'(TIMEOUT_TICKS - 1));
  assign w_sum         = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign w_check_good  = (state_q == S_CHECK) && (w_sum == frame_q[7:0]);
  assign w_can_retry   = (attempt_q <= AW'(MAX_RETRY));
  // error beats done; a frame arriving on the timeout tick is still accepted
  assign w_attempt_fail = ((state_q == S_WAIT) && (ctr_error || (!ctr_done && w_timeout_hit)))
                       || ((state_q == S_CHECK) && (w_sum != frame_q[7:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HOLDOFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_issue_idle) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (ctr_error)          state_d = S_HOLDOFF;
        else if (ctr_done)      state_d = S_CHECK;
        else if (w_timeout_hit) state_d = S_HOLDOFF;
      end
      S_CHECK:   state_d = S_HOLDOFF;
      S_HOLDOFF: if (w_settle_hit) state_d = retry_q ? S_ISSUE : S_IDLE;
      default:   state_d = S_HOLDOFF;
    endcase
  end

  always_comb begin
    period_cnt_d  = period_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    attempt_d     = attempt_q;
    retry_d       = retry_q;
    frame_d       = frame_q;
    humidity_d    = humidity_q;
    temperature_d = temperature_q;
    data_valid_d  = data_valid_q;
    fail_d        = fail_q;
    err_count_d   = err_count_q;

    if (!enable)          period_cnt_d = '0;
    else if (tick_10msec) period_cnt_d = w_period_hit ? '0 : period_cnt_q + 1'b1;

    pend_d = (enable && (pend_q || w_period_hit)) || manual_req;
    if (w_issue_idle) pend_d = 1'b0;

    if (state_q != S_HOLDOFF) settle_cnt_d = '0;
    else if (tick_10msec)     settle_cnt_d = w_settle_hit ? '0 : settle_cnt_q + 1'b1;
    if ((state_q == S_HOLDOFF) && w_settle_hit && retry_q) retry_d = 1'b0;

    if (state_q == S_ISSUE) begin
      attempt_d     = attempt_q + 1'b1;
      timeout_cnt_d = '0;
    end else if ((state_q == S_WAIT) && tick_10msec) begin
      timeout_cnt_d = timeout_cnt_q + 1'b1;
    end

    if ((state_q == S_WAIT) && ctr_done && !ctr_error) frame_d = ctr_frame;

    if (w_check_good) begin
      humidity_d    = frame_q[39:32];
      temperature_d = frame_q[23:16];
      data_valid_d  = 1'b1;
      fail_d        = 1'b0;
      attempt_d     = '0;
      retry_d       = 1'b0;
    end

    if (w_attempt_fail) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      if (w_can_retry) begin
        retry_d = 1'b1;
      end else begin
        fail_d    = 1'b1;
        attempt_d = '0;
        retry_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q  <= '0;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      attempt_q     <= '0;
      pend_q        <= 1'b0;
      retry_q       <= 1'b0;
      frame_q       <= '0;
      humidity_q    <= '0;
      temperature_q <= '0;
      data_valid_q  <= 1'b0;
      fail_q        <= 1'b0;
      err_count_q   <= '0;
    end else begin
      period_cnt_q  <= period_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      attempt_q     <= attempt_d;
      pend_q        <= pend_d;
      retry_q       <= retry_d;
      frame_q       <= frame_d;
      humidity_q    <= humidity_d;
      temperature_q <= temperature_d;
      data_valid_q  <= data_valid_d;
      fail_q        <= fail_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    start_req   = (state_q == S_ISSUE);
    sched_busy  = (state_q != S_IDLE);
    sched_state = state_q;
    humidity    = humidity_q;
    temperature = temperature_q;
    data_valid  = data_valid_q;
    fail        = fail_q;
    err_count   = err_count_q;
  end

endmodule

`default_nettype wire
